// File: rtl/wb_trace_buffer.sv
// MEM/WB retirement trace buffer: captures retiring instructions into a FWFT FIFO and drains
// them to the trace port over valid/ready, requesting a pipeline stall before the FIFO fills.
module wb_trace_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned SKID  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        have_inst_in,
  input  logic [31:0] pc_in,
  input  logic        rf_we_in,
  input  logic [4:0]  wR_in,
  input  logic [31:0] wD_in,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic        trace_wen,
  output logic [4:0]  trace_wreg,
  output logic [31:0] trace_wdata,
  output logic        stall_req,
  output logic        overflow,
  output logic [31:0] retire_cnt
);

  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);
  localparam logic [AW:0] SkidCnt = (AW + 1)'(SKID);

  logic [31:0] pc_mem    [DEPTH];
  logic        wen_mem   [DEPTH];
  logic [4:0]  wreg_mem  [DEPTH];
  logic [31:0] wdata_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   free_d;
  logic          stall_q, stall_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   retire_q, retire_d;

  logic        push, pop, full;
  logic        norm_wen;
  logic [4:0]  norm_wreg;
  logic [31:0] norm_wdata;

  always_comb begin
    trace_valid = (count_q != '0);
    pop         = trace_valid & trace_ready;
    full        = (count_q == FullCnt);
    // A full FIFO can still accept when the head leaves in the same cycle.
    push        = have_inst_in & (~full | pop);

    // Writes to x0 or with write disabled are recorded as "no write" with zeroed fields.
    norm_wen   = rf_we_in & (wR_in != 5'd0);
    norm_wreg  = norm_wen ? wR_in : 5'd0;
    norm_wdata = norm_wen ? wD_in : 32'd0;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    free_d     = FullCnt - count_d;
    stall_d    = (free_d <= SkidCnt);
    overflow_d = overflow_q | (have_inst_in & full & ~pop);
    retire_d   = push ? retire_q + 32'd1 : retire_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
      retire_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
      retire_q   <= retire_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[wr_ptr_q]    <= pc_in;
      wen_mem[wr_ptr_q]   <= norm_wen;
      wreg_mem[wr_ptr_q]  <= norm_wreg;
      wdata_mem[wr_ptr_q] <= norm_wdata;
    end
  end

  always_comb begin
    trace_pc    = trace_valid ? pc_mem[rd_ptr_q]    : 32'd0;
    trace_wen   = trace_valid ? wen_mem[rd_ptr_q]   : 1'b0;
    trace_wreg  = trace_valid ? wreg_mem[rd_ptr_q]  : 5'd0;
    trace_wdata = trace_valid ? wdata_mem[rd_ptr_q] : 32'd0;
    stall_req   = stall_q;
    overflow    = overflow_q;
    retire_cnt  = retire_q;
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: a vector table for single-entry behaviour plus
// hand-written sequences for fill/overflow, full push+pop across wrap, and reset mid-drain.
module tb_wb_trace_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        have_inst_in;
  logic [31:0] pc_in;
  logic        rf_we_in;
  logic [4:0]  wR_in;
  logic [31:0] wD_in;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic        trace_wen;
  logic [4:0]  trace_wreg;
  logic [31:0] trace_wdata;
  logic        stall_req;
  logic        overflow;
  logic [31:0] retire_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DEPTH(8), .AW(3), .SKID(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .have_inst_in (have_inst_in),
    .pc_in        (pc_in),
    .rf_we_in     (rf_we_in),
    .wR_in        (wR_in),
    .wD_in        (wD_in),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_pc     (trace_pc),
    .trace_wen    (trace_wen),
    .trace_wreg   (trace_wreg),
    .trace_wdata  (trace_wdata),
    .stall_req    (stall_req),
    .overflow     (overflow),
    .retire_cnt   (retire_cnt)
  );

  typedef struct {
    logic        have;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        ready;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_wen;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;
    logic        e_stall;
    logic        e_ovf;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic have, input logic [31:0] pc, input logic we,
                       input logic [4:0] wr, input logic [31:0] wd, input logic ready);
    have_inst_in = have;
    pc_in        = pc;
    rf_we_in     = we;
    wR_in        = wr;
    wD_in        = wd;
    trace_ready  = ready;
  endtask

  initial begin
    // Idle x2, single retire + drain, x0 normalisation, rf_we=0, push/pop at count=1.
    vecs[0] = '{1'b0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b1,
                1'b0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'd0};
    vecs[1] = '{1'b0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b1,
                1'b0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'd0};
    vecs[2] = '{1'b1, 32'h4,  1'b1, 5'd5,  32'hDEAD_BEEF, 1'b1,
                1'b1, 32'h4,  1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 1'b0, 32'd1};
    vecs[3] = '{1'b0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b1,
                1'b0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'd1};
    vecs[4] = '{1'b1, 32'h10, 1'b1, 5'd0,  32'h1234,     1'b0,
                1'b1, 32'h10, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'd2};
    vecs[5] = '{1'b0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b1,
                1'b0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'd2};
    vecs[6] = '{1'b1, 32'h20, 1'b0, 5'd7,  32'h55,       1'b1,
                1'b1, 32'h20, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'd3};
    vecs[7] = '{1'b1, 32'h24, 1'b1, 5'd31, 32'hCAFE_F00D, 1'b1,
                1'b1, 32'h24, 1'b1, 5'd31, 32'hCAFE_F00D, 1'b0, 1'b0, 32'd4};
    vecs[8] = '{1'b0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b1,
                1'b0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'd4};

    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    tick();
    tick();
    chk("rst_valid",  32'(trace_valid), 32'd0);
    chk("rst_stall",  32'(stall_req),   32'd0);
    chk("rst_ovf",    32'(overflow),    32'd0);
    chk("rst_cnt",    retire_cnt,       32'd0);
    chk("rst_pc",     trace_pc,         32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].have, vecs[i].pc, vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].ready);
      tick();
      chk($sformatf("v%0d_valid", i), 32'(trace_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_pc", i),    trace_pc,          vecs[i].e_pc);
      chk($sformatf("v%0d_wen", i),   32'(trace_wen),    32'(vecs[i].e_wen));
      chk($sformatf("v%0d_wreg", i),  32'(trace_wreg),   32'(vecs[i].e_wreg));
      chk($sformatf("v%0d_wdata", i), trace_wdata,       vecs[i].e_wdata);
      chk($sformatf("v%0d_stall", i), 32'(stall_req),    32'(vecs[i].e_stall));
      chk($sformatf("v%0d_ovf", i),   32'(overflow),     32'(vecs[i].e_ovf));
      chk($sformatf("v%0d_cnt", i),   retire_cnt,        vecs[i].e_cnt);
    end

    // Backpressure fill: stall asserts once 6 entries are held, 9th retire overflows.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 32'(4 * (k - 1)), 1'b1, 5'd1, 32'(k), 1'b0);
      tick();
      chk($sformatf("fill%0d_stall", k), 32'(stall_req), (k >= 6) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d_head", k),  trace_pc,       32'h0);
    end
    chk("fill_ovf_pre", 32'(overflow), 32'd0);
    drive(1'b1, 32'h20, 1'b1, 5'd1, 32'h9, 1'b0);
    tick();
    chk("fill_ovf", 32'(overflow), 32'd1);
    chk("fill_cnt", retire_cnt,    32'd12);
    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_valid", k), 32'(trace_valid), 32'd1);
      chk($sformatf("drain%0d_pc", k),    trace_pc,         32'(4 * k));
      chk($sformatf("drain%0d_wdata", k), trace_wdata,      32'(k + 1));
      tick();
      // count after this pop is 7-k; stall while free <= 2
      chk($sformatf("drain%0d_stall", k), 32'(stall_req), (k <= 1) ? 32'd1 : 32'd0);
    end
    chk("drain_empty", 32'(trace_valid), 32'd0);
    chk("drain_ovf_sticky", 32'(overflow), 32'd1);

    // Full with simultaneous push and pop, across pointer wrap.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_ovf", 32'(overflow), 32'd0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), 1'b1, 5'd2, 32'h0, 1'b0);
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 32'h200 + 32'(4 * j), 1'b1, 5'd2, 32'h0, 1'b1);
      chk($sformatf("fp%0d_head", j), trace_pc, 32'h100 + 32'(4 * j));
      tick();
      chk($sformatf("fp%0d_ovf", j),   32'(overflow),  32'd0);
      chk($sformatf("fp%0d_stall", j), 32'(stall_req), 32'd1);
      chk($sformatf("fp%0d_cnt", j),   retire_cnt,     32'd9 + 32'(j));
    end
    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("wrap%0d_pc", k), trace_pc,
          (k < 4) ? 32'h110 + 32'(4 * k) : 32'h200 + 32'(4 * (k - 4)));
      tick();
    end
    chk("wrap_empty", 32'(trace_valid), 32'd0);

    // Reset during a handshake discards buffered entries.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h300 + 32'(4 * k), 1'b1, 5'd3, 32'h0, 1'b0);
      tick();
    end
    chk("mid_valid_pre", 32'(trace_valid), 32'd1);
    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_valid", 32'(trace_valid), 32'd0);
    chk("mid_cnt",   retire_cnt,       32'd0);
    tick();
    chk("mid_idle", 32'(trace_valid), 32'd0);
    drive(1'b1, 32'h400, 1'b1, 5'd3, 32'h77, 1'b0);
    tick();
    chk("post_pc",    trace_pc,    32'h400);
    chk("post_wdata", trace_wdata, 32'h77);
    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    tick();
    chk("post_alone", 32'(trace_valid), 32'd0);
    chk("post_cnt",   retire_cnt,       32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
